// File: rtl/roce_rnr_retry_timer_if.sv
// rtl/roce_rnr_retry_timer_if.sv - AETH event input and retransmit-request output of the RNR retry timer
//   s_aeth_valid/s_aeth_syndrome/s_aeth_psn : AETH event strobe from the parser
//   retry_req_valid/retry_req_ready/retry_psn : retransmit request handshake to the requester
//   slave modport = timer side, master modport = parser/requester side
interface roce_rnr_retry_timer_if;
  logic        s_aeth_valid;
  logic [7:0]  s_aeth_syndrome;
  logic [23:0] s_aeth_psn;
  logic        retry_req_valid;
  logic        retry_req_ready;
  logic [23:0] retry_psn;

  modport slave (
    input  s_aeth_valid,
    input  s_aeth_syndrome,
    input  s_aeth_psn,
    input  retry_req_ready,
    output retry_req_valid,
    output retry_psn
  );

  modport master (
    output s_aeth_valid,
    output s_aeth_syndrome,
    output s_aeth_psn,
    output retry_req_ready,
    input  retry_req_valid,
    input  retry_psn
  );
endinterface

// File: rtl/roce_rnr_retry_timer.sv
// rtl/roce_rnr_retry_timer.sv - RNR NAK backoff timer and retry budget for one RoCEv2 QP
//   clk, rst_n      : clock, asynchronous active-low reset
//   qp_init         : pulse, re-arm QP, load budget, abort pending wait/request
//   cfg_rnr_retry   : RNR retry budget, 7 = infinite
//   bus (slave)     : AETH events in, retransmit request (valid/ready/psn) out
//   timer_active    : high while waiting out an RNR delay
//   rnr_retry_left  : remaining budget
//   qp_error        : sticky, budget exhausted
module roce_rnr_retry_timer #(
  parameter int TIMER_SHIFT = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   qp_init,
  input  logic [2:0]             cfg_rnr_retry,
  roce_rnr_retry_timer_if.slave  bus,
  output logic                   timer_active,
  output logic [2:0]             rnr_retry_left,
  output logic                   qp_error
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REQ, ST_ERR} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // IB RNR timer encodings, in microsecond ticks. Index 0 is the longest (655.36 ms).
  function automatic logic [31:0] rnr_table(input logic [4:0] idx);
    case (idx)
      5'd0:  rnr_table = 32'd655360;
      5'd1:  rnr_table = 32'd10;
      5'd2:  rnr_table = 32'd20;
      5'd3:  rnr_table = 32'd30;
      5'd4:  rnr_table = 32'd40;
      5'd5:  rnr_table = 32'd60;
      5'd6:  rnr_table = 32'd80;
      5'd7:  rnr_table = 32'd120;
      5'd8:  rnr_table = 32'd160;
      5'd9:  rnr_table = 32'd240;
      5'd10: rnr_table = 32'd320;
      5'd11: rnr_table = 32'd480;
      5'd12: rnr_table = 32'd640;
      5'd13: rnr_table = 32'd960;
      5'd14: rnr_table = 32'd1280;
      5'd15: rnr_table = 32'd1920;
      5'd16: rnr_table = 32'd2560;
      5'd17: rnr_table = 32'd3840;
      5'd18: rnr_table = 32'd5120;
      5'd19: rnr_table = 32'd7680;
      5'd20: rnr_table = 32'd10240;
      5'd21: rnr_table = 32'd15360;
      5'd22: rnr_table = 32'd20480;
      5'd23: rnr_table = 32'd30720;
      5'd24: rnr_table = 32'd40960;
      5'd25: rnr_table = 32'd61440;
      5'd26: rnr_table = 32'd81920;
      5'd27: rnr_table = 32'd122880;
      5'd28: rnr_table = 32'd163840;
      5'd29: rnr_table = 32'd245760;
      5'd30: rnr_table = 32'd327680;
      default: rnr_table = 32'd491520;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [23:0]           psn_q, psn_d;
  logic [2:0]            left_q, left_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  active_q, active_d;
  // Events are ignored between reset and the first qp_init.
  logic                  armed_q, armed_d;

  logic                  is_ack;
  logic                  is_nak;
  logic [CNT_WIDTH-1:0]  shifted_cnt;
  logic [CNT_WIDTH-1:0]  load_cnt;

  assign is_ack = bus.s_aeth_valid && (bus.s_aeth_syndrome[7:5] == 3'b000);
  assign is_nak = bus.s_aeth_valid && (bus.s_aeth_syndrome[7:5] == 3'b001);

  // Truncate to the counter width first, then floor to one so a tiny
  // post-shift delay still spends one cycle in WAIT.
  assign shifted_cnt = CNT_WIDTH'(rnr_table(bus.s_aeth_syndrome[4:0]) >> TIMER_SHIFT);
  assign load_cnt    = (shifted_cnt == '0) ? CNT_ONE : shifted_cnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    psn_d   = psn_q;
    left_d  = left_q;
    err_d   = err_q;
    armed_d = armed_q;

    if (qp_init) begin
      state_d = ST_IDLE;
      left_d  = cfg_rnr_retry;
      err_d   = 1'b0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      case (state_q)
        ST_IDLE, ST_WAIT: begin
          if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_REQ;
          end
          if (is_ack) left_d = cfg_rnr_retry;
          // A NAK arriving on the expiry edge still wins and restarts the wait.
          if (is_nak) begin
            if (cfg_rnr_retry == 3'd7) begin
              state_d = ST_WAIT;
              cnt_d   = load_cnt;
              psn_d   = bus.s_aeth_psn;
            end else if (left_q == 3'd0) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else begin
              left_d  = left_q - 3'd1;
              state_d = ST_WAIT;
              cnt_d   = load_cnt;
              psn_d   = bus.s_aeth_psn;
            end
          end
        end
        ST_REQ: begin
          if (is_ack) left_d = cfg_rnr_retry;
          if (bus.retry_req_ready) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end

    valid_d  = (state_d == ST_REQ);
    active_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      psn_q    <= '0;
      left_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      psn_q    <= psn_d;
      left_q   <= left_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      armed_q  <= armed_d;
    end
  end

  assign bus.retry_req_valid = valid_q;
  assign bus.retry_psn       = psn_q;
  assign timer_active        = active_q;
  assign rnr_retry_left      = left_q;
  assign qp_error            = err_q;

endmodule
